// File: rtl/signed_subtractor.sv
// Registered two's-complement subtractor (out = a + ~b + cin) with of/cf/zf/nf flags.
// Define SIGNED_SUB_INPUT_REG_EN to add an input register stage (2-cycle latency).
module signed_subtractor #(
  parameter int WIDTH = 32  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             valid_out,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic             cf,
  output logic             zf,
  output logic             nf
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             op_valid;

`ifdef SIGNED_SUB_INPUT_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             valid_in_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      valid_in_q <= 1'b0;
    end else begin
      a_q        <= a;
      b_q        <= b;
      cin_q      <= cin;
      valid_in_q <= valid_in;
    end
  end

  assign op_a     = a_q;
  assign op_b     = b_q;
  assign op_cin   = cin_q;
  assign op_valid = valid_in_q;
`else
  assign op_a     = a;
  assign op_b     = b;
  assign op_cin   = cin;
  assign op_valid = valid_in;
`endif

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign p = op_a ^ ~op_b;
  assign g = op_a & ~op_b;

  // Carries inside each 4-bit group are looked ahead from the group carry-in;
  // only the group carry ripples from one group to the next.
  always_comb begin
    logic [3:0] pv;
    logic [3:0] gv;
    logic       ci;
    logic       gg;
    logic       pp;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pv   = '0;
    gv   = '0;
    ci   = 1'b0;
    gg   = 1'b0;
    pp   = 1'b0;
    c    = '0;
    c[0] = op_cin;
    for (int k = 0; k < NG; k++) begin
      pv = p[4*k +: 4];
      gv = g[4*k +: 4];
      ci = c[4*k];
      c[4*k+1] = gv[0] | (pv[0] & ci);
      c[4*k+2] = gv[1] | (pv[1] & gv[0]) | (pv[1] & pv[0] & ci);
      c[4*k+3] = gv[2] | (pv[2] & gv[1]) | (pv[2] & pv[1] & gv[0])
               | (pv[2] & pv[1] & pv[0] & ci);
      gg = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1])
         | (pv[3] & pv[2] & pv[1] & gv[0]);
      pp = &pv;
      c[4*k+4] = gg | (pp & ci);
    end
  end

  assign sum = p ^ c[WIDTH-1:0];

  logic [WIDTH-1:0] out_q, out_d;
  logic             of_q, of_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             valid_q, valid_d;

  always_comb begin
    out_d   = out_q;
    of_d    = of_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    valid_d = op_valid;
    if (op_valid) begin
      out_d = sum;
      of_d  = (op_a[WIDTH-1] == ~op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      cf_d  = c[WIDTH];
      zf_d  = (sum == '0);
      nf_d  = sum[WIDTH-1];
    end
  end

  // NOTE: reset is sampled on the clock edge only, and state updates use <= so all
  // registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      of_q    <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      of_q    <= of_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign of        = of_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign nf        = nf_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_signed_subtractor.sv
// Self-checking bench for signed_subtractor: directed spec vectors plus randomized
// traffic against an integer-arithmetic reference model.
module tb_signed_subtractor;

  localparam int W = 32;
`ifdef SIGNED_SUB_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [W-1:0] a, b;
  logic         cin;
  logic         valid_out;
  logic [W-1:0] out;
  logic         of, cf, zf, nf;

  signed_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .cin(cin),
    .valid_out(valid_out), .out(out), .of(of), .cf(cf), .zf(zf), .nf(nf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         has_k;      // spec-given expected result attached
    logic [W-1:0] k_out;
    logic [3:0]   k_flg;      // {of, cf, zf, nf}
  } op_t;

  int n_cmp = 0;
  int n_bad = 0;

  op_t          stage;        // op captured by the input stage (2-cycle build)
  logic [W-1:0] m_out;
  logic [3:0]   m_flg;
  logic         m_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true integer difference, range check for overflow, unsigned compare for carry.
  task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc,
                         output logic [W-1:0] ro, output logic [3:0] rf);
    longint t;
    logic   v, c;
    t  = longint'($signed(ra)) - longint'($signed(rb)) - (rc ? 64'sd0 : 64'sd1);
    ro = t[W-1:0];
    v  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    c  = rc ? (ra >= rb) : (ra > rb);
    rf = {v, c, (ro == 0), ro[W-1]};
  endtask

  function automatic op_t mk(input logic v, input logic [W-1:0] oa, input logic [W-1:0] ob,
                             input logic oc);
    op_t o;
    o.v = v; o.a = oa; o.b = ob; o.cin = oc;
    o.has_k = 1'b0; o.k_out = '0; o.k_flg = '0;
    return o;
  endfunction

  // Apply one cycle of stimulus, advance the model, compare just after the edge.
  task automatic step(input logic rst, input op_t op);
    op_t done;
    rst_n    = ~rst;
    valid_in = op.v;
    a        = op.a;
    b        = op.b;
    cin      = op.cin;
    @(posedge clk);
    #1;
    done = (LAT == 1) ? op : stage;
    if (rst) begin
      m_out = '0; m_flg = '0; m_valid = 1'b0;
      stage = mk(1'b0, '0, '0, 1'b0);
    end else begin
      m_valid = done.v;
      if (done.v) ref_sub(done.a, done.b, done.cin, m_out, m_flg);
      stage = op;
    end
    check("valid_out", {63'd0, valid_out}, {63'd0, m_valid});
    check("out", {32'd0, out}, {32'd0, m_out});
    check("flags", {60'd0, of, cf, zf, nf}, {60'd0, m_flg});
    if (!rst && done.v && done.has_k) begin
      check("spec_out", {32'd0, out}, {32'd0, done.k_out});
      check("spec_flags", {60'd0, of, cf, zf, nf}, {60'd0, done.k_flg});
    end
  endtask

  task automatic spec_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input logic [W-1:0] ko, input logic [3:0] kf);
    op_t o;
    o = mk(1'b1, oa, ob, oc);
    o.has_k = 1'b1; o.k_out = ko; o.k_flg = kf;
    step(1'b0, o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, mk(1'b0, $urandom, $urandom, $urandom_range(1)));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    stage = mk(1'b0, '0, '0, 1'b0);
    m_out = '0; m_flg = '0; m_valid = 1'b0;

    // Reset with a live operation on the inputs.
    step(1'b1, mk(1'b1, 32'd5, 32'd3, 1'b1));
    step(1'b1, mk(1'b1, 32'd5, 32'd3, 1'b1));

    spec_op(32'd56455654, 32'd454545462, 1'b1, -32'sd398089808, 4'b0001);
    idle(LAT);
    spec_op(-32'sd55677887, -32'sd976465405, 1'b1, 32'd920787518, 4'b0100);
    idle(LAT);
    spec_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 4'b1001);
    idle(LAT);
    spec_op(-32'sd566575, -32'sd566575, 1'b1, 32'd0, 4'b0110);
    spec_op(32'd6754276, -32'sd6754276, 1'b1, 32'd13508552, 4'b0000);
    idle(LAT);
    spec_op(32'd10, 32'd3, 1'b0, 32'd6, 4'b0100);
    idle(3 + LAT);
    spec_op(32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b0001);
    spec_op(32'd0, 32'h8000_0000, 1'b1, 32'h8000_0000, 4'b1001);
    spec_op(32'd123, 32'h8000_0000, 1'b1, 32'h8000_007B, 4'b1001);
    idle(LAT);

    // Reset mid-stream discards the in-flight op.
    step(1'b0, mk(1'b1, 32'd77, 32'd11, 1'b1));
    step(1'b1, mk(1'b1, 32'd99, 32'd1, 1'b1));
    step(1'b0, mk(1'b0, 32'd0, 32'd0, 1'b0));
    idle(LAT);

    // Random traffic with mixed valid, corner operands and rare resets.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: rb = ra;
        1: rb = 32'h8000_0000;
        2: ra = 32'h7FFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      step($urandom_range(39) == 0, mk($urandom_range(3) != 0, ra, rb, $urandom_range(1)));
    end
    idle(LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1);
  end

endmodule
